// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//
// Holds the MD_* operation codes used by the decoder and the EX stage
// (they sit beside the ALU_* codes in the wider codebase), the two-state
// sequencing enum, and a small helper for sizing the busy counter.
// ---------------------------------------------------------------------------
package mdu_pkg;

    // Operation codes carried on mdop (4 bits). Codes 9..15 are undefined
    // and are treated exactly like MD_NONE.
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    // Sequencer states: idle, or a multiply/divide counting down.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Larger of two integers; used to size the shared busy counter.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage : mdu_pkg

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- MIPS-style HI/LO multiply/divide unit.
//
// Multiplies and divides are computed behaviourally in the acceptance cycle
// into pending registers; a down-counter then models the multi-cycle
// latency, and HI/LO take the pending values on the completion edge.
// mthi/mtlo write HI/LO directly at acceptance. mfhi/mflo are served
// combinationally on result.
//
// Ports:
//   clk    in   1  clock, all state on rising edge
//   reset  in   1  asynchronous, active-low reset
//   start  in   1  mdop carries a new operation this cycle
//   mdop   in   4  operation code (MD_* in mdu_pkg)
//   A      in  32  rs operand
//   B      in  32  rt operand
//   busy   out  1  multiply/divide in flight
//   hi     out 32  architectural HI
//   lo     out 32  architectural LO
//   result out 32  mfhi/mflo read value, 0 for other codes
// ---------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] result
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    mdu_state_e     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]    hi_r;
    logic [31:0]    lo_r;
    logic [31:0]    pend_hi_r;
    logic [31:0]    pend_lo_r;
    logic           pend_wr_r;

    logic           busy_s;
    logic [63:0]    a_ext_s;
    logic [63:0]    b_ext_s;
    logic [63:0]    prod_s;
    logic           div_zero_s;
    logic           div_ovf_s;
    logic [31:0]    divisor_s;
    logic [31:0]    sq_s;
    logic [31:0]    sr_s;
    logic [31:0]    uq_s;
    logic [31:0]    ur_s;

    logic           long_op_s;
    logic [CNT_W-1:0] cnt_load_s;
    logic [31:0]    pend_hi_n_s;
    logic [31:0]    pend_lo_n_s;
    logic           pend_wr_n_s;
    logic           wr_hi_now_s;
    logic           wr_lo_now_s;

    // The counter is nonzero only while RUN, but both terms are kept so busy
    // stays asserted even if the two ever disagree.
    assign busy_s = (state_r == ST_RUN) || (cnt_r != {CNT_W{1'b0}});
    assign busy   = busy_s;
    assign hi     = hi_r;
    assign lo     = lo_r;

    // Arithmetic datapath: 64-bit product and guarded quotient/remainder.
    always_comb begin
        a_ext_s    = {32'h0000_0000, A};
        b_ext_s    = {32'h0000_0000, B};
        if (mdop == MD_MULT) begin
            // Sign-extend so the low 64 bits of the product are the signed result.
            a_ext_s = {{32{A[31]}}, A};
            b_ext_s = {{32{B[31]}}, B};
        end else begin
            a_ext_s = {32'h0000_0000, A};
            b_ext_s = {32'h0000_0000, B};
        end
        prod_s     = a_ext_s * b_ext_s;

        // Never divide by zero in the datapath; the write is suppressed instead.
        div_zero_s = (B == 32'h0000_0000);
        div_ovf_s  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        if (div_zero_s) begin
            divisor_s = 32'h0000_0001;
        end else begin
            divisor_s = B;
        end

        uq_s = A / divisor_s;
        ur_s = A % divisor_s;
        if (div_ovf_s) begin
            // Most-negative / -1 wraps back to itself with no remainder.
            sq_s = 32'h8000_0000;
            sr_s = 32'h0000_0000;
        end else begin
            sq_s = $signed(A) / $signed(divisor_s);
            sr_s = $signed(A) % $signed(divisor_s);
        end
    end

    // Operation decode: what to latch and how long to stay busy.
    always_comb begin
        long_op_s   = 1'b0;
        cnt_load_s  = {CNT_W{1'b0}};
        pend_hi_n_s = 32'h0000_0000;
        pend_lo_n_s = 32'h0000_0000;
        pend_wr_n_s = 1'b0;
        wr_hi_now_s = 1'b0;
        wr_lo_now_s = 1'b0;
        case (mdop)
            MD_MULT, MD_MULTU: begin
                long_op_s   = 1'b1;
                cnt_load_s  = CNT_W'(MULT_CYCLES - 1);
                pend_hi_n_s = prod_s[63:32];
                pend_lo_n_s = prod_s[31:0];
                pend_wr_n_s = 1'b1;
            end
            MD_DIV: begin
                long_op_s   = 1'b1;
                cnt_load_s  = CNT_W'(DIV_CYCLES - 1);
                pend_hi_n_s = sr_s;
                pend_lo_n_s = sq_s;
                pend_wr_n_s = !div_zero_s;
            end
            MD_DIVU: begin
                long_op_s   = 1'b1;
                cnt_load_s  = CNT_W'(DIV_CYCLES - 1);
                pend_hi_n_s = ur_s;
                pend_lo_n_s = uq_s;
                pend_wr_n_s = !div_zero_s;
            end
            MD_MTHI: begin
                wr_hi_now_s = 1'b1;
            end
            MD_MTLO: begin
                wr_lo_now_s = 1'b1;
            end
            default: begin
                long_op_s   = 1'b0;
            end
        endcase
    end

    // mfhi/mflo read port; deliberately ignores start and busy.
    always_comb begin
        result = 32'h0000_0000;
        case (mdop)
            MD_MFHI: result = hi_r;
            MD_MFLO: result = lo_r;
            default: result = 32'h0000_0000;
        endcase
    end

    // Sequencer, busy counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= 32'h0000_0000;
            lo_r      <= 32'h0000_0000;
            pend_hi_r <= 32'h0000_0000;
            pend_lo_r <= 32'h0000_0000;
            pend_wr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !busy_s) begin
                        if (long_op_s) begin
                            state_r   <= ST_RUN;
                            cnt_r     <= cnt_load_s;
                            pend_hi_r <= pend_hi_n_s;
                            pend_lo_r <= pend_lo_n_s;
                            pend_wr_r <= pend_wr_n_s;
                        end
                        if (wr_hi_now_s) begin
                            hi_r <= A;
                        end
                        if (wr_lo_now_s) begin
                            lo_r <= A;
                        end
                    end
                end
                ST_RUN: begin
                    // start is ignored here: busy is high for the whole of RUN.
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        if (pend_wr_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule : mdu

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- directed self-checking bench for mdu.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int vectors;
    int miscompares;
    int n;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdop   (mdop),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single rising edge, return on the next falling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mdop  = MD_NONE;
    endtask

    // Count falling-edge samples with busy=1; optionally pulse a mult at sample inj.
    task automatic count_busy(input int inj, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == inj) begin
                start = 1'b1;
                mdop  = MD_MULT;
                A     = 32'd2;
                B     = 32'd3;
            end else begin
                start = 1'b0;
                mdop  = MD_NONE;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mdop  = MD_NONE;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        start = 1'b0;
        mdop  = MD_MFHI;
        A     = 32'h0;
        B     = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_result", result, 32'h0);
        mdop  = MD_NONE;
        reset = 1'b1;
        @(negedge clk);

        // Signed multiply: -2 * 3 = -6
        issue(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult_busy_t0", {31'h0, busy}, 32'h1);
        check("mult_hi_held", hi, 32'h0);
        count_busy(0, n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // Unsigned multiply: 0xFFFFFFFF * 2
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        count_busy(0, n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // Undefined opcode and MD_NONE are ignored
        issue(4'hF, 32'h5555_5555, 32'h6666_6666);
        check("undef_busy", {31'h0, busy}, 32'h0);
        check("undef_hi", hi, 32'h0000_0001);
        issue(MD_NONE, 32'h5555_5555, 32'h6666_6666);
        check("none_lo", lo, 32'hFFFF_FFFE);

        // Signed divide -7 / 2 then reads
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        count_busy(0, n);
        check("div_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        mdop = MD_MFLO;
        #1;
        check("mflo_result", result, 32'hFFFF_FFFD);
        mdop = MD_MFHI;
        #1;
        check("mfhi_result", result, 32'hFFFF_FFFF);
        mdop = MD_NONE;
        #1;
        check("none_result", result, 32'h0);

        // Unsigned divide 100 / 7
        issue(MD_DIVU, 32'd100, 32'd7);
        count_busy(0, n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // mthi/mtlo then divide by zero with an ignored start at busy cycle 3
        issue(MD_MTHI, 32'h0000_0011, 32'h0);
        check("mthi_busy", {31'h0, busy}, 32'h0);
        check("mthi_hi", hi, 32'h0000_0011);
        issue(MD_MTLO, 32'h0000_0022, 32'h0);
        check("mtlo_lo", lo, 32'h0000_0022);
        issue(MD_DIVU, 32'h0000_1234, 32'h0);
        count_busy(3, n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", hi, 32'h0000_0011);
        check("div0_lo", lo, 32'h0000_0022);
        @(negedge clk);
        check("div0_after_busy", {31'h0, busy}, 32'h0);

        // Reset mid-operation at busy cycle 2
        issue(MD_DIV, 32'd100, 32'd7);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst_busy", {31'h0, busy}, 32'h0);

        // Signed overflow: 0x80000000 / -1
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(0, n);
        check("ovf_cycles", n, 32'd10);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mdu
